// File: rtl/c2f_req_ctrl.sv
// c2f_req_ctrl: core-to-fabric initiator; queues remote core loads/stores for the ring
// and tracks one outstanding remote read per hardware thread.
module c2f_req_ctrl #(
    parameter  int FIFO_DEPTH  = 4,
    parameter  int NUM_THREADS = 4,
    localparam int TID_W       = $clog2(NUM_THREADS)
) (
    input  logic                   QClk,
    input  logic                   RstQnnnL,
    input  logic [7:0]             CoreIdStrap,
    input  logic [NUM_THREADS-1:0] ThreadQ103H,
    input  logic [31:0]            AddressQ103H,
    input  logic [3:0]             ByteEnQ103H,
    input  logic [31:0]            WrDataQ103H,
    input  logic                   RdEnQ103H,
    input  logic                   WrEnQ103H,
    output logic                   C2F_FullQ103H,
    output logic [NUM_THREADS-1:0] C2F_ThreadStallQnnnH,
    output logic                   C2F_RdRspValidQ104H,
    output logic [NUM_THREADS-1:0] C2F_RdRspThreadQ104H,
    output logic [31:0]            C2F_RdRspDataQ104H,
    output logic                   C2F_ReqValid,
    input  logic                   C2F_ReqReady,
    output logic [1:0]             C2F_ReqOpcode,
    output logic [31:0]            C2F_ReqAddress,
    output logic [31:0]            C2F_ReqData,
    output logic [3:0]             C2F_ReqByteEn,
    output logic [TID_W-1:0]       C2F_ReqThread,
    input  logic                   F2C_RspValid,
    input  logic [TID_W-1:0]       F2C_RspThread,
    input  logic [31:0]            F2C_RspData,
    output logic                   C2F_ErrSticky
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [1:0]       op;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [3:0]       be;
        logic [TID_W-1:0] thr;
    } req_t;

    req_t                   mem_q [FIFO_DEPTH];
    req_t                   entry_d;
    req_t                   head;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_THREADS-1:0] pend_q, pend_d, pend_set, pend_clr;
    logic [NUM_THREADS-1:0] rsp_thr_q, rsp_thr_d;
    logic [31:0]            rsp_data_q, rsp_data_d;
    logic                   rsp_vld_q, rsp_vld_d;
    logic                   err_q, err_d;
    logic [TID_W-1:0]       thr_enc;
    logic                   remote, full, rd_dup, push, pop, rsp_hit;

    always_comb begin
        thr_enc = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--)
            if (ThreadQ103H[i]) thr_enc = TID_W'(i);
    end

    assign remote = (RdEnQ103H | WrEnQ103H) && AddressQ103H[31:24] != 8'h00
                    && AddressQ103H[31:24] != CoreIdStrap;
    assign full   = cnt_q == CNT_W'(FIFO_DEPTH);
    assign rd_dup = RdEnQ103H && pend_q[thr_enc];
    // Space is judged on the registered count only: a same-cycle pop never makes room.
    assign push   = remote && !full && !rd_dup;
    assign pop    = cnt_q != '0 && C2F_ReqReady;
    assign rsp_hit = F2C_RspValid && pend_q[F2C_RspThread];

    always_comb begin
        entry_d    = '{op: RdEnQ103H ? 2'b01 : 2'b10, addr: AddressQ103H, data: WrDataQ103H,
                       be: ByteEnQ103H, thr: thr_enc};
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
        pend_set   = (push && RdEnQ103H) ? NUM_THREADS'(1) << thr_enc : '0;
        pend_clr   = rsp_hit ? NUM_THREADS'(1) << F2C_RspThread : '0;
        pend_d     = (pend_q & ~pend_clr) | pend_set;
        rsp_vld_d  = rsp_hit;
        rsp_thr_d  = rsp_hit ? pend_clr : rsp_thr_q;
        rsp_data_d = rsp_hit ? F2C_RspData : rsp_data_q;
        err_d      = err_q | (remote && (full || rd_dup)) | (F2C_RspValid && !rsp_hit);
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_thr_q  <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_thr_q  <= rsp_thr_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: payload outputs are gated by valid.
    always_ff @(posedge QClk) begin
        if (push) mem_q[wr_ptr_q] <= entry_d;
    end

    assign head                 = mem_q[rd_ptr_q];
    assign C2F_ReqValid         = cnt_q != '0;
    assign C2F_ReqOpcode        = C2F_ReqValid ? head.op : 2'b00;
    assign C2F_ReqAddress       = C2F_ReqValid ? head.addr : '0;
    assign C2F_ReqData          = C2F_ReqValid ? head.data : '0;
    assign C2F_ReqByteEn        = C2F_ReqValid ? head.be : '0;
    assign C2F_ReqThread        = C2F_ReqValid ? head.thr : '0;
    assign C2F_FullQ103H        = full;
    assign C2F_ThreadStallQnnnH = pend_q;
    assign C2F_RdRspValidQ104H  = rsp_vld_q;
    assign C2F_RdRspThreadQ104H = rsp_thr_q;
    assign C2F_RdRspDataQ104H   = rsp_data_q;
    assign C2F_ErrSticky        = err_q;
endmodule

// File: tb/tb_c2f_req_ctrl.sv
// tb_c2f_req_ctrl: directed vector table plus randomized traffic against a queue-based model.
module tb_c2f_req_ctrl;
    logic        QClk = 1'b0;
    logic        RstQnnnL = 1'b0;
    logic [7:0]  CoreIdStrap = 8'h05;
    logic [3:0]  ThreadQ103H = '0;
    logic [31:0] AddressQ103H = '0;
    logic [3:0]  ByteEnQ103H = '0;
    logic [31:0] WrDataQ103H = '0;
    logic        RdEnQ103H = 1'b0;
    logic        WrEnQ103H = 1'b0;
    logic        C2F_ReqReady = 1'b0;
    logic        F2C_RspValid = 1'b0;
    logic [1:0]  F2C_RspThread = '0;
    logic [31:0] F2C_RspData = '0;
    logic        C2F_FullQ103H, C2F_RdRspValidQ104H, C2F_ReqValid, C2F_ErrSticky;
    logic [3:0]  C2F_ThreadStallQnnnH, C2F_RdRspThreadQ104H, C2F_ReqByteEn;
    logic [31:0] C2F_RdRspDataQ104H, C2F_ReqAddress, C2F_ReqData;
    logic [1:0]  C2F_ReqOpcode, C2F_ReqThread;

    c2f_req_ctrl dut (
        .QClk(QClk), .RstQnnnL(RstQnnnL), .CoreIdStrap(CoreIdStrap),
        .ThreadQ103H(ThreadQ103H), .AddressQ103H(AddressQ103H), .ByteEnQ103H(ByteEnQ103H),
        .WrDataQ103H(WrDataQ103H), .RdEnQ103H(RdEnQ103H), .WrEnQ103H(WrEnQ103H),
        .C2F_FullQ103H(C2F_FullQ103H), .C2F_ThreadStallQnnnH(C2F_ThreadStallQnnnH),
        .C2F_RdRspValidQ104H(C2F_RdRspValidQ104H), .C2F_RdRspThreadQ104H(C2F_RdRspThreadQ104H),
        .C2F_RdRspDataQ104H(C2F_RdRspDataQ104H), .C2F_ReqValid(C2F_ReqValid),
        .C2F_ReqReady(C2F_ReqReady), .C2F_ReqOpcode(C2F_ReqOpcode),
        .C2F_ReqAddress(C2F_ReqAddress), .C2F_ReqData(C2F_ReqData),
        .C2F_ReqByteEn(C2F_ReqByteEn), .C2F_ReqThread(C2F_ReqThread),
        .F2C_RspValid(F2C_RspValid), .F2C_RspThread(F2C_RspThread),
        .F2C_RspData(F2C_RspData), .C2F_ErrSticky(C2F_ErrSticky)
    );

    always #5 QClk = ~QClk;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [1:0]  thr;
    } req_t;

    typedef struct {
        logic        rd, wr;
        logic [3:0]  thr;
        logic [31:0] addr, data;
        logic        rdy, rspv;
        logic [1:0]  tag;
        logic [31:0] rdata;
        logic        e_v;
        logic [1:0]  e_op;
        logic [31:0] e_addr, e_data;
        logic [1:0]  e_thr;
        logic        e_full;
        logic [3:0]  e_stall;
        logic        e_rv;
        logic [3:0]  e_rthr;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    int n_checks = 0;
    int n_pass = 0;

    req_t        mq[$];
    logic [3:0]  m_pend;
    logic        m_err, m_rv;
    logic [3:0]  m_rthr;
    logic [31:0] m_rdata;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = '0; m_err = 0; m_rv = 0; m_rthr = '0; m_rdata = '0;
    endtask

    task automatic model_check();
        chk("req_valid", 80'(C2F_ReqValid), 80'(mq.size() != 0));
        if (mq.size() != 0)
            chk("req_payload", 80'({C2F_ReqOpcode, C2F_ReqAddress, C2F_ReqData, C2F_ReqByteEn, C2F_ReqThread}), 80'(mq[0]));
        else
            chk("idle_payload", 80'({C2F_ReqOpcode, C2F_ReqAddress, C2F_ReqData, C2F_ReqByteEn, C2F_ReqThread}), 80'(0));
        chk("full", 80'(C2F_FullQ103H), 80'(mq.size() == 4));
        chk("stall", 80'(C2F_ThreadStallQnnnH), 80'(m_pend));
        chk("rsp_valid", 80'(C2F_RdRspValidQ104H), 80'(m_rv));
        if (m_rv) chk("rsp_payload", 80'({C2F_RdRspThreadQ104H, C2F_RdRspDataQ104H}), 80'({m_rthr, m_rdata}));
        chk("err", 80'(C2F_ErrSticky), 80'(m_err));
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_next();
        logic       remote, do_push, do_pop;
        int         tid;
        logic [3:0] pend_old;
        req_t       e;
        pend_old = m_pend;
        tid = 0;
        for (int i = 0; i < 4; i++) if (ThreadQ103H[i]) tid = i;
        remote = (RdEnQ103H || WrEnQ103H) && AddressQ103H[31:24] != 0 && AddressQ103H[31:24] != CoreIdStrap;
        do_pop = mq.size() != 0 && C2F_ReqReady;
        do_push = 0;
        if (remote) begin
            if (mq.size() == 4 || (RdEnQ103H && pend_old[tid])) m_err = 1;
            else do_push = 1;
        end
        m_rv = 0;
        if (F2C_RspValid) begin
            if (pend_old[F2C_RspThread]) begin
                m_rv = 1; m_rthr = 4'b1 << F2C_RspThread; m_rdata = F2C_RspData;
                m_pend[F2C_RspThread] = 0;
            end else m_err = 1;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            e.op = RdEnQ103H ? 2'b01 : 2'b10; e.addr = AddressQ103H; e.data = WrDataQ103H;
            e.be = ByteEnQ103H; e.thr = 2'(tid);
            mq.push_back(e);
            if (RdEnQ103H) m_pend[tid] = 1;
        end
    endtask

    task automatic finish_cycle();
        model_check();
        model_next();
        @(posedge QClk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [3:0] thr, input logic [31:0] addr,
                         input logic [31:0] data, input logic rdy, input logic rspv, input logic [1:0] tag,
                         input logic [31:0] rdata);
        RdEnQ103H = rd; WrEnQ103H = wr; ThreadQ103H = thr; AddressQ103H = addr; WrDataQ103H = data;
        ByteEnQ103H = 4'hF; C2F_ReqReady = rdy; F2C_RspValid = rspv; F2C_RspThread = tag; F2C_RspData = rdata;
    endtask

    task automatic do_reset();
        drive(0, 0, 4'b0001, 0, 0, 0, 0, 0, 0);
        RstQnnnL = 0;
        repeat (2) @(posedge QClk);
        #1;
        RstQnnnL = 1;
        model_reset();
    endtask

    vec_t tbl[$];
    int   hs;

    initial begin
        //              rd wr thr      addr          data          rdy rspv tag rdata         | v op    e_addr        e_data        thr full stall    rv rthr     e_rdata       err
        tbl.push_back('{0, 1, 4'b0010, 32'h03000010, 32'hDEADBEEF, 1, 0, 0, 0,             0, 2'b00, 32'h0,        32'h0,        0, 0, 4'b0000, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{0, 0, 4'b0010, 32'h0,        32'h0,        1, 0, 0, 0,             1, 2'b10, 32'h03000010, 32'hDEADBEEF, 1, 0, 4'b0000, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{1, 0, 4'b0001, 32'h00000004, 32'h0,        1, 0, 0, 0,             0, 2'b00, 32'h0,        32'h0,        0, 0, 4'b0000, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{1, 0, 4'b0001, 32'h05000004, 32'h0,        1, 0, 0, 0,             0, 2'b00, 32'h0,        32'h0,        0, 0, 4'b0000, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{0, 0, 4'b0001, 32'h0,        32'h0,        1, 0, 0, 0,             0, 2'b00, 32'h0,        32'h0,        0, 0, 4'b0000, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{1, 0, 4'b0100, 32'h07000100, 32'h0,        0, 0, 0, 0,             0, 2'b00, 32'h0,        32'h0,        0, 0, 4'b0000, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{0, 0, 4'b0001, 32'h0,        32'h0,        0, 0, 0, 0,             1, 2'b01, 32'h07000100, 32'h0,        2, 0, 4'b0100, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{0, 0, 4'b0001, 32'h0,        32'h0,        1, 0, 0, 0,             1, 2'b01, 32'h07000100, 32'h0,        2, 0, 4'b0100, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{0, 0, 4'b0001, 32'h0,        32'h0,        1, 1, 2, 32'h12345678,  0, 2'b00, 32'h0,        32'h0,        0, 0, 4'b0100, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{0, 0, 4'b0001, 32'h0,        32'h0,        1, 0, 0, 0,             0, 2'b00, 32'h0,        32'h0,        0, 0, 4'b0000, 1, 4'b0100, 32'h12345678, 0});
        tbl.push_back('{0, 0, 4'b0001, 32'h0,        32'h0,        1, 0, 0, 0,             0, 2'b00, 32'h0,        32'h0,        0, 0, 4'b0000, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{0, 1, 4'b0001, 32'h0A000000, 32'h11,       0, 0, 0, 0,             0, 2'b00, 32'h0,        32'h0,        0, 0, 4'b0000, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{0, 1, 4'b0001, 32'h0A000004, 32'h22,       0, 0, 0, 0,             1, 2'b10, 32'h0A000000, 32'h11,       0, 0, 4'b0000, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{0, 1, 4'b0001, 32'h0A000008, 32'h33,       0, 0, 0, 0,             1, 2'b10, 32'h0A000000, 32'h11,       0, 0, 4'b0000, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{0, 1, 4'b0001, 32'h0A00000C, 32'h44,       0, 0, 0, 0,             1, 2'b10, 32'h0A000000, 32'h11,       0, 0, 4'b0000, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{0, 1, 4'b0001, 32'h0A000010, 32'h55,       0, 0, 0, 0,             1, 2'b10, 32'h0A000000, 32'h11,       0, 1, 4'b0000, 0, 4'b0000, 32'h0,        0});
        tbl.push_back('{0, 0, 4'b0001, 32'h0,        32'h0,        1, 0, 0, 0,             1, 2'b10, 32'h0A000000, 32'h11,       0, 1, 4'b0000, 0, 4'b0000, 32'h0,        1});
        tbl.push_back('{0, 0, 4'b0001, 32'h0,        32'h0,        1, 0, 0, 0,             1, 2'b10, 32'h0A000004, 32'h22,       0, 0, 4'b0000, 0, 4'b0000, 32'h0,        1});
        tbl.push_back('{0, 0, 4'b0001, 32'h0,        32'h0,        1, 0, 0, 0,             1, 2'b10, 32'h0A000008, 32'h33,       0, 0, 4'b0000, 0, 4'b0000, 32'h0,        1});
        tbl.push_back('{0, 0, 4'b0001, 32'h0,        32'h0,        1, 0, 0, 0,             1, 2'b10, 32'h0A00000C, 32'h44,       0, 0, 4'b0000, 0, 4'b0000, 32'h0,        1});
        tbl.push_back('{0, 0, 4'b0001, 32'h0,        32'h0,        1, 0, 0, 0,             0, 2'b00, 32'h0,        32'h0,        0, 0, 4'b0000, 0, 4'b0000, 32'h0,        1});

        do_reset();
        foreach (tbl[n]) begin
            drive(tbl[n].rd, tbl[n].wr, tbl[n].thr, tbl[n].addr, tbl[n].data, tbl[n].rdy,
                  tbl[n].rspv, tbl[n].tag, tbl[n].rdata);
            #4;
            chk($sformatf("tbl%0d_valid", n), 80'(C2F_ReqValid), 80'(tbl[n].e_v));
            chk($sformatf("tbl%0d_req", n), 80'({C2F_ReqOpcode, C2F_ReqAddress, C2F_ReqData, C2F_ReqThread}),
                80'({tbl[n].e_op, tbl[n].e_addr, tbl[n].e_data, tbl[n].e_thr}));
            chk($sformatf("tbl%0d_full", n), 80'(C2F_FullQ103H), 80'(tbl[n].e_full));
            chk($sformatf("tbl%0d_stall", n), 80'(C2F_ThreadStallQnnnH), 80'(tbl[n].e_stall));
            chk($sformatf("tbl%0d_rspv", n), 80'(C2F_RdRspValidQ104H), 80'(tbl[n].e_rv));
            if (tbl[n].e_rv)
                chk($sformatf("tbl%0d_rsp", n), 80'({C2F_RdRspThreadQ104H, C2F_RdRspDataQ104H}),
                    80'({tbl[n].e_rthr, tbl[n].e_rdata}));
            chk($sformatf("tbl%0d_err", n), 80'(C2F_ErrSticky), 80'(tbl[n].e_err));
            finish_cycle();
        end

        // Ready toggling while pushing across several pointer wraps.
        do_reset();
        hs = 0;
        for (int i = 0; i < 34; i++) begin
            drive(0, i % 2 == 0 && i < 26, 4'b1 << (i % 4), 32'h0B000000 + 32'(4 * i), $urandom,
                  i % 4 != 3, 0, 0, 0);
            #4;
            if (C2F_ReqValid && C2F_ReqReady) hs++;
            finish_cycle();
        end
        chk("wrap_handshakes", 80'(hs), 80'(13));

        // Second read from a thread whose read is still outstanding.
        drive(1, 0, 4'b0001, 32'h09000000, 0, 1, 0, 0, 0);
        #4; finish_cycle();
        drive(1, 0, 4'b0001, 32'h09000040, 0, 1, 0, 0, 0);
        #4; finish_cycle();
        drive(0, 0, 4'b0001, 0, 0, 1, 0, 0, 0);
        #4;
        chk("dup_read_err", 80'(C2F_ErrSticky), 80'(1));
        chk("dup_read_stall", 80'(C2F_ThreadStallQnnnH), 80'(4'b0001));
        finish_cycle();
        chk("dup_read_issued_once", 80'(C2F_ReqValid), 80'(0));

        do_reset();
        for (int i = 0; i < 600; i++) begin
            int   r;
            logic [7:0] id;
            logic [3:0] thr;
            logic [1:0] tag;
            logic rspv;
            r = $urandom_range(0, 9);
            id = 8'($urandom_range(1, 255));
            if (id == CoreIdStrap) id = 8'h06;
            if (r == 6) id = ($urandom_range(0, 1) != 0) ? CoreIdStrap : 8'h00;
            thr = 4'b1 << $urandom_range(0, 3);
            rspv = 0; tag = 2'($urandom_range(0, 3));
            if (m_pend != 0 && $urandom_range(0, 2) == 0) begin
                rspv = 1;
                while (!m_pend[tag]) tag = tag + 1'b1;
            end else if ($urandom_range(0, 59) == 0) rspv = 1;
            drive(r < 3 || r == 6, r >= 3 && r < 6, thr, {id, 24'($urandom)}, $urandom,
                  1'($urandom_range(0, 1)), rspv, tag, $urandom);
            ByteEnQ103H = 4'($urandom);
            #4;
            finish_cycle();
        end

        // Reset asserted asynchronously in the middle of a burst.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, i != 0, 4'b0010, 32'h0C000000 + 32'(i), 32'(i), 0, 0, 0, 0);
            #4; finish_cycle();
        end
        drive(1, 0, 4'b0010, 32'h0C000100, 0, 0, 0, 0, 0);
        #4; finish_cycle();
        drive(0, 0, 4'b0001, 0, 0, 0, 0, 0, 0);
        #2;
        RstQnnnL = 0;
        #1;
        chk("rst_req_side", 80'({C2F_ReqValid, C2F_ReqOpcode, C2F_ReqAddress, C2F_ReqData, C2F_ReqByteEn, C2F_ReqThread}), 80'(0));
        chk("rst_rsp_side", 80'({C2F_FullQ103H, C2F_ThreadStallQnnnH, C2F_RdRspValidQ104H, C2F_RdRspThreadQ104H, C2F_RdRspDataQ104H, C2F_ErrSticky}), 80'(0));
        model_reset();
        @(posedge QClk);
        #1;
        RstQnnnL = 1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 4'b0001, 0, 0, 1, 0, 0, 0);
            #4; finish_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
